// File: rtl/sequenceur_lancer_if.sv
// Roll request / result bundle between the choice logic (master) and the
// roll sequencer (slave).
interface sequenceur_lancer_if;
  logic        lancer;
  logic [2:0]  idD;
  logic [3:0]  nbD;
  logic        chargerGraine;
  logic [15:0] graine;
  logic        pret;
  logic [6:0]  valeur;
  logic        valeurValide;
  logic [10:0] somme;
  logic        fini;

  modport master (
    output lancer, idD, nbD, chargerGraine, graine,
    input  pret, valeur, valeurValide, somme, fini
  );

  modport slave (
    input  lancer, idD, nbD, chargerGraine, graine,
    output pret, valeur, valeurValide, somme, fini
  );
endinterface

// File: rtl/sequenceur_lancer.sv
// Dice roll sequencer: draws die values by masked rejection sampling from a
// 16-bit Fibonacci LFSR, streams each value and accumulates the roll total.

module bornerD (
  input  logic [2:0] idD,
  output logic [6:0] dMin,
  output logic [6:0] dMax
);
  always_comb begin
    dMin = 7'd1;
    dMax = 7'd4;
    case (idD)
      3'd0: begin dMin = 7'd1; dMax = 7'd4;   end
      3'd1: begin dMin = 7'd1; dMax = 7'd6;   end
      3'd2: begin dMin = 7'd1; dMax = 7'd8;   end
      3'd3: begin dMin = 7'd0; dMax = 7'd9;   end
      3'd4: begin dMin = 7'd1; dMax = 7'd12;  end
      3'd5: begin dMin = 7'd1; dMax = 7'd20;  end
      3'd6: begin dMin = 7'd1; dMax = 7'd30;  end
      default: begin dMin = 7'd0; dMax = 7'd99; end
    endcase
  end
endmodule

module sequenceur_lancer (
  input  logic                clk,
  input  logic                rst,
  sequenceur_lancer_if.slave  bus
);
  typedef enum logic [1:0] {
    REPOS  = 2'd0,
    TIRAGE = 2'd1,
    FIN    = 2'd2
  } state_t;

  localparam logic [15:0] GRAINE_DEFAUT = 16'hACE1;

  state_t      state, state_next;
  logic [2:0]  id_q;
  logic [3:0]  reste;
  logic [15:0] lfsr;
  logic [6:0]  valeur_q;
  logic        valide_q;
  logic [10:0] somme_q;

  logic [6:0]  d_min, d_max, span, mask, cand, tirage;
  logic        accept_roll, draw_ok;

  bornerD u_borner (
    .idD  (id_q),
    .dMin (d_min),
    .dMax (d_max)
  );

  // Smear the span's top bit downward to get the smallest all-ones mask >= span.
  assign span   = d_max - d_min;
  assign mask   = span | (span >> 1) | (span >> 2) | (span >> 4);
  assign cand   = lfsr[6:0] & mask;
  assign tirage = d_min + cand;

  assign accept_roll = (state == REPOS) && bus.lancer;
  assign draw_ok     = (state == TIRAGE) && (cand <= span);

  // NOTE: all sequential state below uses non-blocking assignments so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= GRAINE_DEFAUT;
    end else if (bus.chargerGraine) begin
      lfsr <= (bus.graine == 16'd0) ? GRAINE_DEFAUT : bus.graine;
    end else begin
      lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= REPOS;
    else     state <= state_next;
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      REPOS:   if (bus.lancer) state_next = TIRAGE;
      TIRAGE:  if (draw_ok && reste == 4'd1) state_next = FIN;
      FIN:     state_next = REPOS;
      default: state_next = REPOS;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_q     <= 3'd0;
      reste    <= 4'd0;
      valeur_q <= 7'd0;
      valide_q <= 1'b0;
      somme_q  <= 11'd0;
    end else begin
      valide_q <= 1'b0;
      if (accept_roll) begin
        id_q    <= bus.idD;
        reste   <= (bus.nbD == 4'd0) ? 4'd1 : bus.nbD;
        somme_q <= 11'd0;
      end else if (draw_ok) begin
        valeur_q <= tirage;
        valide_q <= 1'b1;
        somme_q  <= somme_q + {4'd0, tirage};
        reste    <= reste - 4'd1;
      end
    end
  end

  assign bus.pret         = (state == REPOS);
  assign bus.fini         = (state == FIN);
  assign bus.valeur       = valeur_q;
  assign bus.valeurValide = valide_q;
  assign bus.somme        = somme_q;
endmodule

// File: tb/tb_sequenceur_lancer.sv
// Directed self-checking bench for sequenceur_lancer with an LFSR reference
// model predicting each roll's values, sum and completion cycle.
module tb_sequenceur_lancer;
  logic clk;
  logic rst;
  sequenceur_lancer_if sif ();

  sequenceur_lancer dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int dmin_t [8] = '{1, 1, 1, 0, 1, 1, 1, 0};
  int dmax_t [8] = '{4, 6, 8, 9, 12, 20, 30, 99};
  int mask_t [8] = '{3, 7, 7, 15, 15, 31, 31, 127};

  logic [15:0] m_lfsr;
  int got_vals [16];
  int got_n, got_sum, got_cyc, exp_cyc, exp_rej;
  int first_vals [16];

  function automatic logic [15:0] lfsr_nxt(input logic [15:0] v);
    return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
  endfunction

  always @(posedge clk) begin
    if (rst)                    m_lfsr <= 16'hACE1;
    else if (sif.chargerGraine) m_lfsr <= (sif.graine == 16'd0) ? 16'hACE1 : sif.graine;
    else                        m_lfsr <= lfsr_nxt(m_lfsr);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Starts a roll in REPOS, predicts it from the model LFSR, monitors it to
  // completion and checks values, sum, latency and the post-roll state.
  task automatic do_roll(input int id, input int nb, input int hold, input string tag);
    logic [15:0] l;
    int exp_vals [16];
    int e_n, e_sum, rem, cyc, cand, pret_hi, fin_sum;
    sif.idD    = 3'(id);
    sif.nbD    = 4'(nb);
    sif.lancer = 1'b1;
    @(posedge clk);
    @(negedge clk);
    l = m_lfsr;
    check({tag, "_lfsr_c1"}, 32'(dut.lfsr), 32'(l));
    rem = (nb == 0) ? 1 : nb;
    e_n = 0; e_sum = 0; cyc = 1; exp_rej = 0;
    while (rem > 0) begin
      cand = int'(l[6:0]) & mask_t[id];
      if (cand <= dmax_t[id] - dmin_t[id]) begin
        exp_vals[e_n] = dmin_t[id] + cand;
        e_sum += exp_vals[e_n];
        e_n++;
        rem--;
      end else begin
        exp_rej++;
      end
      l = lfsr_nxt(l);
      cyc++;
    end
    exp_cyc = cyc;
    got_n = 0; got_cyc = 0; pret_hi = 0; fin_sum = -1;
    for (int k = 1; k <= 400 && got_cyc == 0; k++) begin
      if (k > 1) @(negedge clk);
      if (k == hold) sif.lancer = 1'b0;
      if (sif.valeurValide) begin
        if (got_n < 16) got_vals[got_n] = int'(sif.valeur);
        got_n++;
      end
      if (sif.pret) pret_hi++;
      if (sif.fini) begin
        got_cyc = k;
        fin_sum = int'(sif.somme);
      end
    end
    sif.lancer = 1'b0;
    got_sum = fin_sum;
    check({tag, "_fini_cycle"}, 32'(got_cyc), 32'(exp_cyc));
    check({tag, "_pulses"}, 32'(got_n), 32'(e_n));
    check({tag, "_pret_low"}, 32'(pret_hi), 32'd0);
    check({tag, "_somme"}, 32'(fin_sum), 32'(e_sum));
    for (int i = 0; i < e_n; i++) begin
      check({tag, "_val"}, (i < got_n) ? 32'(got_vals[i]) : 32'hFFFF_FFFF, 32'(exp_vals[i]));
      if (i < got_n)
        check({tag, "_range"}, 32'(got_vals[i] >= dmin_t[id] && got_vals[i] <= dmax_t[id]), 32'd1);
    end
    @(negedge clk);
    check({tag, "_fini_1cyc"}, 32'(sif.fini), 32'd0);
    check({tag, "_pret_after"}, 32'(sif.pret), 32'd1);
    check({tag, "_somme_held"}, 32'(sif.somme), 32'(e_sum));
    check({tag, "_valeur_held"}, 32'(sif.valeur), (e_n > 0) ? 32'(exp_vals[e_n - 1]) : 32'd0);
  endtask

  initial begin
    int quiet;
    rst               = 1'b1;
    sif.lancer        = 1'b0;
    sif.idD           = 3'd0;
    sif.nbD           = 4'd0;
    sif.chargerGraine = 1'b0;
    sif.graine        = 16'd0;

    // Reset held for two cycles
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("rst_pret", 32'(sif.pret), 32'd1);
    check("rst_somme", 32'(sif.somme), 32'd0);
    check("rst_valeur", 32'(sif.valeur), 32'd0);
    check("rst_fini", 32'(sif.fini), 32'd0);
    check("rst_valide", 32'(sif.valeurValide), 32'd0);
    check("rst_lfsr", 32'(dut.lfsr), 32'hACE1);
    rst = 1'b0;

    // d4 x 3 from seed 0x1234: never rejects, fini exactly in cycle 4
    sif.chargerGraine = 1'b1;
    sif.graine        = 16'h1234;
    @(negedge clk);
    sif.chargerGraine = 1'b0;
    check("seed_1234", 32'(dut.lfsr), 32'h1234);
    do_roll(0, 3, 1, "d4x3");
    check("d4x3_exact_latency", 32'(got_cyc), 32'd4);

    // d100 x 15: latency 16 plus model rejections, sum bounded
    do_roll(7, 15, 1, "d100x15");
    check("d100x15_latency", 32'(got_cyc), 32'(16 + exp_rej));
    check("d100x15_sum_max", 32'(got_sum <= 1485), 32'd1);

    // d10 with nbD 0 and lancer held into TIRAGE: one die, no second roll
    do_roll(3, 0, 2, "d10n0");
    quiet = 0;
    for (int k = 0; k < 4; k++) begin
      if (sif.valeurValide || !sif.pret || sif.fini) quiet++;
      @(negedge clk);
    end
    check("d10n0_no_requeue", 32'(quiet), 32'd0);

    // Zero seed maps to default; same seed reproduces the same sequence
    sif.chargerGraine = 1'b1;
    sif.graine        = 16'h0000;
    @(negedge clk);
    sif.chargerGraine = 1'b0;
    check("seed0_lfsr", 32'(dut.lfsr), 32'hACE1);
    do_roll(1, 5, 1, "d6a");
    for (int i = 0; i < 5; i++) first_vals[i] = got_vals[i];
    sif.chargerGraine = 1'b1;
    @(negedge clk);
    sif.chargerGraine = 1'b0;
    check("seed0_lfsr_again", 32'(dut.lfsr), 32'hACE1);
    do_roll(1, 5, 1, "d6b");
    for (int i = 0; i < 5; i++)
      check("repeat_seq", 32'(got_vals[i]), 32'(first_vals[i]));

    // Reset in the second TIRAGE cycle of d20 x 8 aborts the roll
    sif.idD    = 3'd5;
    sif.nbD    = 4'd8;
    sif.lancer = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sif.lancer = 1'b0;
    check("abort_c1_pret", 32'(sif.pret), 32'd0);
    check("abort_c1_fini", 32'(sif.fini), 32'd0);
    @(negedge clk);
    check("abort_c2_pret", 32'(sif.pret), 32'd0);
    check("abort_c2_fini", 32'(sif.fini), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_pret", 32'(sif.pret), 32'd1);
    check("abort_somme", 32'(sif.somme), 32'd0);
    check("abort_valeur", 32'(sif.valeur), 32'd0);
    check("abort_valide", 32'(sif.valeurValide), 32'd0);
    check("abort_fini", 32'(sif.fini), 32'd0);
    check("abort_lfsr", 32'(dut.lfsr), 32'hACE1);
    do_roll(5, 8, 1, "d20x8");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sequenceur_lancer.md
# sequenceur_lancer

Roll sequencer for the dice datapath. It accepts a roll request (die type `idD`, number of dice `nbD`) and instantiates `bornerD` internally to get the die bounds. It draws one die value per accepted sample from an internal 16-bit LFSR, using masked rejection sampling, and streams each die value out. It accumulates the total and signals completion with a one-cycle `fini` pulse. It sits between the user-input/choice logic and the display/scoring logic.

## Interface
- No parameters. Widths are fixed: die values 7 bits, count 4 bits, sum 11 bits (15 × 99 = 1485).
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `lancer` input 1: roll request; sampled only in REPOS.
- `idD` input 3: die type, 0..7 (d4, d6, d8, d10 0..9, d12, d20, d30, d100 0..99), captured on accept.
- `nbD` input 4: number of dice, captured on accept; 0 is treated as 1.
- `chargerGraine` input 1: load `graine` into the LFSR this cycle.
- `graine` input 16: LFSR seed; a value of 0 is replaced by 16'hACE1.
- `pret` output 1: high in REPOS.
- `valeur` output 7: last die value; held between updates.
- `valeurValide` output 1: one-cycle pulse when `valeur` is updated.
- `somme` output 11: running and final sum; held after `fini`.
- `fini` output 1: one-cycle pulse at roll completion.

## Operation
- Latched at accept: `idD` register, `reste` count (4 bits), and `somme` cleared to 0.
- `bornerD` is driven by the latched `idD` and gives `dMin` and `dMax`.
  - Span = `dMax` − `dMin`.
  - Mask = smallest 2^k−1 ≥ span: d4 3, d6 7, d8 7, d10 15, d12 15, d20 31, d30 31, d100 127.
- LFSR: Fibonacci, polynomial x^16+x^14+x^13+x^11+1.
  - Shifts every cycle in every state, including REPOS.
  - Exception: a cycle with `chargerGraine` = 1 loads the seed instead of shifting. Load has priority over shift.
- Candidate = `lfsr[6:0]` & mask, taken from the current (pre-shift) register value.
- State machine:
  - REPOS: `pret` = 1. On `lancer` = 1: latch the request, then go to TIRAGE.
  - TIRAGE, candidate ≤ span (accept):
    - `valeur` ← `dMin` + candidate; pulse `valeurValide`.
    - `somme` ← `somme` + `dMin` + candidate; `reste` ← `reste` − 1.
    - If `reste` was 1, go to FIN.
  - TIRAGE, candidate > span (reject): nothing updates; stay in TIRAGE and retry next cycle.
  - FIN: `fini` = 1 for exactly one cycle, then go to REPOS.
- `lancer` in TIRAGE or FIN is ignored; it is not queued.
- `chargerGraine` during TIRAGE is legal. It changes the subsequent draws only.
- Reset mid-roll aborts the roll: no `fini`; all outputs take their reset values.
- Unreachable state encodings go to REPOS.

## Timing
- Reset values:
  - state REPOS; `pret` 1.
  - `valeur` 0, `valeurValide` 0, `somme` 0, `fini` 0, `reste` 0.
  - LFSR 16'hACE1.
- Accept edge (cycle 0), with `lancer` = 1 in REPOS:
  - First candidate is evaluated in cycle 1.
  - On each accepted draw, `valeurValide` and the updated `valeur` and `somme` are visible in the cycle after the draw edge.
- Latency without rejections: `fini` is high in cycle n+1 after accept, for n dice. d4 never rejects, so d4 latency is exact.
- Rejections: each adds one cycle. The mask keeps the acceptance rate ≥ 50%.
- Boundedness: the 7-bit window covers all values within the LFSR period, so every draw completes.
- `pret` is low from cycle 1 until the cycle after `fini`.
- Back-to-back rolls: `lancer` held high is re-accepted in the first REPOS cycle, which gives one idle cycle between rolls.
- `somme` is valid and stable when `fini` = 1 and stays stable until the next accept.

## Test plan
- Reset: `rst` for 2 cycles → `pret` 1, `somme` 0, `valeur` 0, `fini` 0, LFSR = 16'hACE1.
- d4 × 3 (`idD` 0, `nbD` 3), seed 16'h1234 loaded beforehand:
  - exactly 3 `valeurValide` pulses, each `valeur` in 1..4;
  - `fini` in cycle 4 after accept;
  - `somme` = sum of the pulses and matches the bench LFSR model bit-exactly.
- d100 × 15 (`idD` 7, `nbD` 15):
  - 15 pulses, each `valeur` in 0..99; `somme` ≤ 1485;
  - cycle count = 16 + rejections from the model.
- `nbD` 0 with d10 → one pulse, `valeur` in 0..9; `lancer` pulsed mid-roll causes no second roll.
- `chargerGraine` with `graine` 0 → LFSR = 16'hACE1; two rolls from the same seed produce identical `valeur` sequences.
- `rst` asserted in the 2nd TIRAGE cycle of d20 × 8 → no `fini`; next cycle is REPOS with `somme` 0; a new roll then completes normally.
